// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared types and constants for the conversion job sequencer.
//   seq_state_t   - sequencer FSM states
//   Def*          - default memory map and timing constants
//   pack_result() - assembles the 16-bit float from sign and 15-bit core result
package conv_seq_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StLdHi,
      StLdLo,
      StLdSgn,
      StHold,
      StRun,
      StRdHi,
      StRdLo,
      StOut
   } seq_state_t;

   localparam int unsigned DefOpndAddr      = 128;
   localparam int unsigned DefResAddr       = 131;
   localparam int unsigned DefResetCycles   = 2;
   localparam int unsigned DefTimeoutCycles = 4096;

   // The sign is whatever the core left in bit 7 of the result high byte.
   function automatic logic [15:0] pack_result(input logic sign, input logic [14:0] mag);
      return {sign, mag};
   endfunction

endpackage

// File: rtl/conv_seq_timer.sv
// conv_seq_timer: clearable up-counter with terminal-count flag.
//   clk, reset - clock and synchronous active-high reset
//   clr        - synchronous clear (wins over en)
//   en         - count enable
//   limit      - terminal count is reached when count == limit-1 and en is high
//   count      - current count
//   tc         - terminal-count flag
module conv_seq_timer #(
   parameter int unsigned Width = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [Width-1:0] limit,
   output logic [Width-1:0] count,
   output logic             tc
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;
   assign tc    = en && (count_q == (limit - 1'b1));

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: runs the 9-bit core through one integer-to-float conversion per job.
//   clk, reset              - clock, synchronous active-high reset
//   job_valid/ready/data    - 16-bit signed-magnitude job input handshake
//   res_valid/ready/data    - 16-bit float result handshake; res_timeout flags an aborted run
//   core_reset, core_done   - core reset control and completion flag
//   mem_own, mem_addr, mem_wen, mem_wdata, mem_rdata - data-memory port while core is parked
//   jobs_done, timeouts     - completed-job (wrapping) and timed-out-job (saturating) counters
module conv_sequencer
   import conv_seq_pkg::*;
#(
   parameter int unsigned OPND_ADDR      = DefOpndAddr,
   parameter int unsigned RES_ADDR       = DefResAddr,
   parameter int unsigned RESET_CYCLES   = DefResetCycles,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [15:0] job_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic        res_timeout,
   output logic        core_reset,
   input  logic        core_done,
   output logic        mem_own,
   output logic [7:0]  mem_addr,
   output logic        mem_wen,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [15:0] jobs_done,
   output logic [7:0]  timeouts
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] OpndHiAddr = 8'(OPND_ADDR);
   localparam logic [7:0] OpndLoAddr = 8'(OPND_ADDR + 1);
   localparam logic [7:0] ResHiAddr  = 8'(RES_ADDR);
   localparam logic [7:0] ResLoAddr  = 8'(RES_ADDR + 1);

   seq_state_t state_q, state_d;
   logic [15:0] job_q, job_d;
   logic [15:0] res_data_q, res_data_d;
   logic        res_timeout_q, res_timeout_d;
   logic [15:0] jobs_done_q, jobs_done_d;
   logic [7:0]  timeouts_q, timeouts_d;

   logic          tmr_clr, tmr_en, tmr_tc;
   logic [TW-1:0] tmr_limit, tmr_count;

   // Timer restarts on every state change, so it counts cycles spent in HOLD or RUN.
   assign tmr_clr   = (state_d != state_q);
   assign tmr_en    = (state_q == StHold) || (state_q == StRun);
   assign tmr_limit = (state_q == StRun) ? TW'(TIMEOUT_CYCLES) : TW'(RESET_CYCLES);

   conv_seq_timer #(
      .Width (TW)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .limit (tmr_limit),
      .count (tmr_count),
      .tc    (tmr_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         job_q         <= '0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
         jobs_done_q   <= '0;
         timeouts_q    <= '0;
      end else begin
         state_q       <= state_d;
         job_q         <= job_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
         jobs_done_q   <= jobs_done_d;
         timeouts_q    <= timeouts_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      job_d         = job_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;
      jobs_done_d   = jobs_done_q;
      timeouts_d    = timeouts_q;
      job_ready     = 1'b0;
      res_valid     = 1'b0;
      core_reset    = 1'b1;
      mem_own       = 1'b1;
      mem_addr      = '0;
      mem_wen       = 1'b0;
      mem_wdata     = '0;

      unique case (state_q)
         StIdle: begin
            job_ready = 1'b1;
            if (job_valid) begin
               job_d   = job_data;
               state_d = StLdHi;
            end
         end
         StLdHi: begin
            mem_addr  = OpndHiAddr;
            mem_wen   = 1'b1;
            mem_wdata = job_q[15:8];
            state_d   = StLdLo;
         end
         StLdLo: begin
            mem_addr  = OpndLoAddr;
            mem_wen   = 1'b1;
            mem_wdata = job_q[7:0];
            state_d   = StLdSgn;
         end
         StLdSgn: begin
            mem_addr  = ResHiAddr;
            mem_wen   = 1'b1;
            mem_wdata = {job_q[15], 7'b0};
            state_d   = StHold;
         end
         StHold: begin
            if (tmr_tc) state_d = StRun;
         end
         StRun: begin
            core_reset = 1'b0;
            mem_own    = 1'b0;
            // A done seen in the first RUN cycle is left over from the previous run.
            if (core_done && (tmr_count != '0)) begin
               state_d = StRdHi;
            end else if (tmr_tc) begin
               res_timeout_d = 1'b1;
               res_data_d    = '0;
               if (timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
               state_d = StOut;
            end
         end
         StRdHi: begin
            mem_addr          = ResHiAddr;
            res_data_d[15:8]  = mem_rdata;
            res_timeout_d     = 1'b0;
            state_d           = StRdLo;
         end
         StRdLo: begin
            mem_addr    = ResLoAddr;
            res_data_d  = pack_result(res_data_q[15], {res_data_q[14:8], mem_rdata});
            jobs_done_d = jobs_done_q + 16'd1;
            state_d     = StOut;
         end
         StOut: begin
            res_valid = 1'b1;
            if (res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign res_data    = res_data_q;
   assign res_timeout = res_timeout_q;
   assign jobs_done   = jobs_done_q;
   assign timeouts    = timeouts_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: randomized scoreboard bench with a behavioural core and data memory.
module tb_conv_sequencer;

   localparam int unsigned RC = 2;
   localparam int unsigned TO = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_valid, job_ready, res_valid, res_ready, res_timeout;
   logic        core_reset, core_done, mem_own, mem_wen;
   logic [15:0] job_data, res_data, jobs_done;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata, timeouts;

   always #5 clk = ~clk;

   conv_sequencer #(
      .OPND_ADDR      (128),
      .RES_ADDR       (131),
      .RESET_CYCLES   (RC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .job_valid   (job_valid),
      .job_ready   (job_ready),
      .job_data    (job_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_timeout (res_timeout),
      .core_reset  (core_reset),
      .core_done   (core_done),
      .mem_own     (mem_own),
      .mem_addr    (mem_addr),
      .mem_wen     (mem_wen),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .jobs_done   (jobs_done),
      .timeouts    (timeouts)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Integer magnitude -> half-precision bits, round to nearest even.
   function automatic logic [14:0] half_mag(input logic [14:0] mag);
      int e, sh, m, rem, hf;
      if (mag == 15'd0) return 15'd0;
      e = 0;
      for (int i = 0; i < 15; i++) if (mag[i]) e = i;
      if (e <= 10) begin
         m = int'(mag) << (10 - e);
      end else begin
         sh  = e - 10;
         m   = int'(mag) >> sh;
         rem = int'(mag) & ((1 << sh) - 1);
         hf  = 1 << (sh - 1);
         if (rem > hf || (rem == hf && (m % 2) == 1)) m++;
         if (m == 2048) begin
            m = 1024;
            e++;
         end
      end
      return 15'(((e + 15) << 10) | (m & 'h3FF));
   endfunction

   // Behavioural data memory and core.
   logic [7:0]  mem [256];
   int          core_lat    = -1;
   bit          core_sticky = 1'b0;
   int          core_cnt    = 0;
   logic        core_done_q = 1'b0;
   logic [14:0] core_res;

   assign mem_rdata = mem[mem_addr];
   assign core_done = core_done_q;
   assign core_res  = half_mag({mem[128][6:0], mem[129]});

   always @(posedge clk) begin
      if (mem_own && mem_wen) mem[mem_addr] <= mem_wdata;
      if (core_reset) begin
         core_cnt <= 0;
         if (!core_sticky) core_done_q <= 1'b0;
      end else begin
         core_cnt <= core_cnt + 1;
         if (core_lat >= 0 && core_cnt == core_lat) begin
            mem[131]    <= {mem[131][7], core_res[14:8]};
            mem[132]    <= core_res[7:0];
            core_done_q <= 1'b1;
         end
      end
   end

   typedef struct {
      logic [15:0] data;
      logic        tmo;
      int          at;
      logic [15:0] njobs;
      logic [7:0]  nto;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] exp_jobs = '0;
   logic [7:0]  exp_to   = '0;
   int          ready_mode = 0;  // 0 always ready, 1 random, 2 hold off first 5 OUT cycles

   // Monitor: compares each presented result against the scoreboard and drives res_ready.
   initial begin
      bit          in_out  = 1'b0;
      bit          prev_hs = 1'b0;
      int          out_cnt = 0;
      logic [15:0] held    = '0;
      exp_t        e;
      res_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_out  = 1'b0;
            prev_hs = 1'b0;
         end else begin
            if (prev_hs) begin
               chk("post_hs_res_valid", res_valid, 0);
               chk("post_hs_job_ready", job_ready, 1);
            end
            if (!core_reset) chk("run_mem_port", {mem_own, mem_wen}, 0);
            if (res_valid) begin
               chk("out_job_ready", job_ready, 0);
               if (!in_out) begin
                  if (sbq.size() == 0) begin
                     chk("unexpected_result", res_valid, 0);
                  end else begin
                     e = sbq.pop_front();
                     chk("res_data", res_data, e.data);
                     chk("res_timeout", res_timeout, e.tmo);
                     chk("res_cycle", cyc, e.at);
                     chk("jobs_done", jobs_done, e.njobs);
                     chk("timeouts", timeouts, e.nto);
                  end
                  held    = res_data;
                  in_out  = 1'b1;
                  out_cnt = 0;
               end else begin
                  chk("res_stable", res_data, held);
               end
               out_cnt++;
            end
            case (ready_mode)
               1:       res_ready = 1'($urandom_range(0, 1));
               2:       res_ready = (out_cnt > 5);
               default: res_ready = 1'b1;
            endcase
            prev_hs = res_valid && res_ready;
            if (prev_hs) in_out = 1'b0;
         end
      end
   end

   // Offers one job; caller is at a negedge. lat < 0 means the core never finishes.
   task automatic issue(input logic [15:0] d, input int lat, input bit expect_res);
      int   n = 0;
      bit   stale;
      int   acc;
      exp_t e;
      while (!job_ready && n < 10000) begin
         @(negedge clk);
         n++;
      end
      if (!job_ready) begin
         chk("job_ready_wait", job_ready, 1);
         return;
      end
      core_lat  = lat;
      stale     = core_sticky && core_done;
      job_valid = 1'b1;
      job_data  = d;
      acc       = cyc;
      if (expect_res) begin
         if (lat < 0) begin
            if (exp_to != 8'hFF) exp_to++;
            e.data = 16'h0000;
            e.tmo  = 1'b0;
            e.tmo  = 1'b1;
            e.at   = acc + 4 + RC + TO;
         end else begin
            exp_jobs++;
            e.data = {d[15], half_mag(d[14:0])};
            e.tmo  = 1'b0;
            e.at   = acc + 4 + RC + (stale ? 1 : lat + 1) + 3;
         end
         e.njobs = exp_jobs;
         e.nto   = exp_to;
         sbq.push_back(e);
      end
      @(negedge clk);
      job_valid = 1'b0;
      job_data  = 16'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || !job_ready) && n < 6000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sbq.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset     = 1'b1;
      job_valid = 1'b0;
      job_data  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("rst_job_ready", job_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_timeout", res_timeout, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_mem_own", mem_own, 1);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_jobs_done", jobs_done, 0);
      chk("rst_timeouts", timeouts, 0);

      // Directed: job 1, core done after 50 cycles.
      ready_mode = 0;
      issue(16'd1, 49, 1'b1);
      drain();
      chk("opnd_hi_written", mem[128], 8'h00);
      chk("opnd_lo_written", mem[129], 8'h01);

      // Directed: 32767 with consumer stalling 5 cycles.
      ready_mode = 2;
      issue(16'd32767, 30, 1'b1);
      drain();
      ready_mode = 0;

      // Core never finishes.
      issue(16'h8005, -1, 1'b1);
      drain();

      // Stale done held across the next job's reset phase.
      core_sticky = 1'b1;
      issue(16'($urandom), 5, 1'b1);
      drain();
      issue(16'($urandom), 0, 1'b1);
      drain();
      core_sticky = 1'b0;

      // Edge operands and random jobs.
      issue(16'h0000, 3, 1'b1);
      issue(16'h8000, 7, 1'b1);
      issue(16'hFFFF, 2, 1'b1);
      issue(16'h8001, 0, 1'b1);
      ready_mode = 1;
      for (int i = 0; i < 25; i++) issue(16'($urandom), int'($urandom_range(0, 40)), 1'b1);
      drain();

      // Reset during RUN abandons the job.
      ready_mode = 0;
      begin
         int n = 0;
         issue(16'h1234, 1000, 1'b0);
         while (core_reset && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("reached_run", core_reset, 0);
         repeat (3) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         chk("midrst_job_ready", job_ready, 1);
         chk("midrst_core_reset", core_reset, 1);
         chk("midrst_res_valid", res_valid, 0);
         chk("midrst_jobs_done", jobs_done, 0);
         chk("midrst_timeouts", timeouts, 0);
         reset    = 1'b0;
         exp_jobs = '0;
         exp_to   = '0;
         core_lat = -1;
      end
      repeat (20) @(negedge clk);
      issue(16'($urandom), 4, 1'b1);
      issue(16'($urandom), 9, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
